// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-state codes and oversampling constants.
// No logic; imported by receiver and transmitter.
// No flow control.
package uart_pkg;

    // Bit-phase codes shared with the transmitter.
    localparam logic [1:0] START_BIT  = 2'b00;
    localparam logic [1:0] DATA_BIT   = 2'b01;
    localparam logic [1:0] PARITY_BIT = 2'b10;
    localparam logic [1:0] STOP_BIT   = 2'b11;

    // Baud ticks per bit, and the tick at which the start bit is re-checked.
    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;
    localparam int TICK_W     = $clog2(OVERSAMPLE);

    typedef logic [TICK_W-1:0] tick_t;

    // Receiver state: MSB set means idle, otherwise the low bits are the bit phase.
    typedef enum logic [2:0] {
        ST_START  = {1'b0, START_BIT},
        ST_DATA   = {1'b0, DATA_BIT},
        ST_PARITY = {1'b0, PARITY_BIT},
        ST_STOP   = {1'b0, STOP_BIT},
        ST_IDLE   = 3'b100
    } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// Latency: 2 clk from input change to q.
// No flow control; samples every cycle.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; both start at the line's idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start qualification, LSB-first data, optional parity, stop check.
// Latency: data_valid one clk after the stop-bit sample tick; start seen 3 clk after the pad edge.
// No backpressure: consumer must accept every data_valid pulse; errored frames are still delivered.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  baud_tick_16x,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_WIDTH - 1);
    localparam tick_t            LAST_TICK = TICK_W'(OVERSAMPLE - 1);
    localparam tick_t            MID_TICK  = TICK_W'(MID_SAMPLE - 1);
    localparam logic             ODD       = (PARITY_ODD != 0);

    logic                  rx_s;
    logic                  rx_s_d;
    logic                  fall;
    rx_state_t             state;
    tick_t                 tick_cnt;
    logic [IDX_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  perr;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    // Delayed copy of the synchronized line for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s_d <= 1'b1;
        end else begin
            rx_s_d <= rx_s;
        end
    end

    assign fall = rx_s_d & ~rx_s;

    // Frame FSM; counters only move on baud ticks, all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            tick_cnt   <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            perr       <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                    if (fall) begin
                        tick_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= ST_START;
                    end
                end

                ST_START: begin
                    if (baud_tick_16x) begin
                        if (tick_cnt == MID_TICK) begin
                            // Mid-bit re-check rejects glitches shorter than half a bit.
                            tick_cnt <= '0;
                            if (!rx_s) begin
                                bit_idx <= '0;
                                perr    <= 1'b0;
                                state   <= ST_DATA;
                            end else begin
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                end

                ST_DATA: begin
                    if (baud_tick_16x) begin
                        // Counter wraps 15 -> 0, so each sample lands one bit later.
                        tick_cnt <= tick_cnt + TICK_W'(1);
                        if (tick_cnt == LAST_TICK) begin
                            shreg <= {rx_s, shreg[DATA_WIDTH-1:1]};
                            if (bit_idx == LAST_IDX) begin
                                state <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                            end else begin
                                bit_idx <= bit_idx + IDX_W'(1);
                            end
                        end
                    end
                end

                ST_PARITY: begin
                    if (baud_tick_16x) begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                        if (tick_cnt == LAST_TICK) begin
                            // Mismatch when received bit differs from the expected parity.
                            perr  <= rx_s ^ (^shreg) ^ ODD;
                            state <= ST_STOP;
                        end
                    end
                end

                ST_STOP: begin
                    if (baud_tick_16x) begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                        if (tick_cnt == LAST_TICK) begin
                            data_out   <= shreg;
                            parity_err <= (PARITY_EN != 0) ? perr : 1'b0;
                            frame_err  <= ~rx_s;
                            data_valid <= 1'b1;
                            busy       <= 1'b0;
                            state      <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames plus glitch, back-to-back and reset sequences.
// Expected results queue up when a frame is driven and are checked on each data_valid.
// Baud tick every 4 clk, so one bit is 64 clk.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud_tick_16x = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    uart_rx #(.DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .baud_tick_16x (baud_tick_16x),
        .rx            (rx),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .parity_err    (parity_err),
        .frame_err     (frame_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       f;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       flip_par;
        logic       stop_bit;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    exp_t sb[$];
    exp_t e;
    vec_t vecs[5];

    int tests = 0;
    int fails = 0;
    int n_valid = 0;
    int bt = 0;
    int last_bt = 0;
    logic dv_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Free-running 16x tick, one clk wide every 4 clk, changed just after the rising edge.
    initial begin : tick_gen
        int div;
        div = 0;
        forever begin
            @(posedge clk);
            #1;
            baud_tick_16x = (div == 3);
            div = (div + 1) % 4;
        end
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            while (!baud_tick_16x) @(negedge clk);
        end
    endtask

    // Drive one complete frame; parity is even unless flipped; line left at stop level.
    task automatic send_frame(input logic [7:0] d, input logic flip_par, input logic stop_bit);
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_ticks(16);
        end
        rx = (^d) ^ flip_par;
        wait_ticks(16);
        rx = stop_bit;
        wait_ticks(16);
    endtask

    // Scoreboard and pulse-shape monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (data_valid) begin
                n_valid++;
                check("valid_expected", (sb.size() > 0), 1);
                check("valid_one_cycle", dv_prev, 0);
                check("busy_low_with_valid", busy, 0);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("data_out", data_out, e.d);
                    check("parity_err", parity_err, e.p);
                    check("frame_err", frame_err, e.f);
                end
            end
            if (busy) begin
                if (baud_tick_16x) bt++;
            end else if (bt != 0) begin
                last_bt = bt;
                bt = 0;
            end
        end else begin
            bt = 0;
        end
        dv_prev = data_valid;
    end

    initial begin : main
        logic [7:0] saved_d;
        logic       saved_p;
        logic       saved_f;
        int         nv0;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'h81, 1'b1, 1'b0, 8'h81, 1'b1, 1'b1};

        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data_out", data_out, 0);
        check("rst_data_valid", data_valid, 0);
        check("rst_parity_err", parity_err, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        wait_ticks(4);

        // Table-driven single frames with an idle gap after each.
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr});
            send_frame(vecs[i].data, vecs[i].flip_par, vecs[i].stop_bit);
            rx = 1'b1;
            wait_ticks(20);
            check("busy_idle_after_frame", busy, 0);
            check("data_out_held", data_out, vecs[i].exp_data);
        end
        check("table_valid_count", n_valid, 5);

        // Short low glitch on an idle line must be rejected.
        saved_d = data_out;
        saved_p = parity_err;
        saved_f = frame_err;
        nv0 = n_valid;
        last_bt = 0;
        rx = 1'b0;
        wait_ticks(4);
        rx = 1'b1;
        wait_ticks(24);
        check("glitch_no_valid", n_valid, nv0);
        check("glitch_data_held", data_out, saved_d);
        check("glitch_perr_held", parity_err, saved_p);
        check("glitch_ferr_held", frame_err, saved_f);
        check("glitch_busy_idle", busy, 0);
        check("glitch_busy_ticks_1_to_9", (last_bt >= 1 && last_bt <= 9), 1);

        // Three frames with no idle gap between them.
        nv0 = n_valid;
        sb.push_back('{8'h01, 1'b0, 1'b0});
        sb.push_back('{8'h80, 1'b0, 1'b0});
        sb.push_back('{8'h55, 1'b0, 1'b0});
        send_frame(8'h01, 1'b0, 1'b1);
        send_frame(8'h80, 1'b0, 1'b1);
        send_frame(8'h55, 1'b0, 1'b1);
        rx = 1'b1;
        wait_ticks(24);
        check("b2b_valid_count", n_valid - nv0, 3);

        // Reset in the middle of data bit 4, then a clean frame.
        nv0 = n_valid;
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            wait_ticks(16);
        end
        rx = 1'b1;
        wait_ticks(8);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_data_out", data_out, 0);
        check("midrst_data_valid", data_valid, 0);
        rst_n = 1'b1;
        wait_ticks(24);
        check("midrst_no_valid", n_valid, nv0);
        sb.push_back('{8'h5A, 1'b0, 1'b0});
        send_frame(8'h5A, 1'b0, 1'b1);
        rx = 1'b1;
        wait_ticks(24);
        check("after_rst_data_out", data_out, 8'h5A);
        check("after_rst_valid_count", n_valid - nv0, 1);

        // Bounded drain of anything still outstanding.
        for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
